// File: rtl/spi_bus_bridge_pkg.sv
// spi_bus_bridge_pkg
//   Shared types and defaults for the SPI slave bridge.
//   - state_t          : frame state machine encoding
//   - WORD_SIZE_DEF    : default frame / bus word width
//   - IDLE_MISO_DEF    : default word shifted out when no response is latched
//   - bit_cnt_w()      : width of a counter able to hold 0..word_size
package spi_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WORD_SIZE_DEF = 16;
  localparam logic [15:0] IDLE_MISO_DEF = 16'h0000;

  function automatic int bit_cnt_w(input int word_size);
    return $clog2(word_size + 1);
  endfunction

  localparam int BIT_CNT_W = bit_cnt_w(WORD_SIZE_DEF);

endpackage

// File: rtl/spi_bus_bridge_pin_sync.sv
// spi_pin_sync
//   Multi-flop synchroniser for one asynchronous pin, plus single-cycle
//   rise/fall pulses derived from the last two synchronised samples.
//   Ports:
//     i_clk, i_rst_n : system clock, async active-low reset
//     i_pin          : asynchronous input pin
//     o_sync         : synchronised level
//     o_rise, o_fall : one-cycle edge pulses on the synchronised level
//   RST_VAL lets idle-high pins (cs_n) reset high so reset release does
//   not look like an edge.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_pin};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge
//   SPI mode-0 slave front end between an external SPI master and the
//   matrix controller bus interfaces. Received frames become rx_valid/rx_data
//   level pulses; response words latched from tx_valid/tx_data are shifted
//   out on MISO. tx_ready pulses after every completed frame to request the
//   next response word.
//   Ports:
//     i_clk, i_rst_n           : system clock (>= 8x sclk), async active-low reset
//     i_spi_sclk/cs_n/mosi     : SPI pins from the master
//     o_spi_miso               : SPI data to the master, MSB first
//     o_rx_valid, o_rx_data    : received word pulse / data
//     o_tx_ready               : request for the next response word
//     i_tx_valid, i_tx_data    : response word write
//     o_err_cnt (optional)     : {tx underruns, aborted frames}, saturating
//   Build option: define SPI_BUS_BRIDGE_ERR_CNT_EN to add o_err_cnt.
//
//   state | meaning
//   IDLE  | cs_n high, miso held 0, sclk ignored
//   SHIFT | frame in progress, shifting on synced sclk edges
//   DONE  | one cycle: publish rx word, start rx/tx pulses, free tx latch
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int RX_PULSE_CYCLES = 4,
  parameter int TX_PULSE_CYCLES = 4,
  parameter logic [WORD_SIZE-1:0] IDLE_MISO_WORD = WORD_SIZE'(IDLE_MISO_DEF)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_spi_sclk,
  input  logic                 i_spi_cs_n,
  input  logic                 i_spi_mosi,
  output logic                 o_spi_miso,
  output logic                 o_rx_valid,
  output logic [WORD_SIZE-1:0] o_rx_data,
  output logic                 o_tx_ready,
  input  logic                 i_tx_valid,
  input  logic [WORD_SIZE-1:0] i_tx_data
`ifdef SPI_BUS_BRIDGE_ERR_CNT_EN
  ,
  output logic [15:0]          o_err_cnt
`endif
);

  localparam int CNT_W = bit_cnt_w(WORD_SIZE);
  localparam int RX_TW = $clog2(RX_PULSE_CYCLES);
  localparam int TX_TW = $clog2(TX_PULSE_CYCLES);

  logic w_sclk_sync_unused, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_sclk),
    .o_sync(w_sclk_sync_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_cs_n),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // mosi only needs the level; same depth keeps it aligned with sclk edges
  logic [SYNC_STAGES-1:0] r_mosi_chain;
  logic                   w_mosi;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_mosi_chain <= '0;
    else          r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], i_spi_mosi};
  end
  assign w_mosi = r_mosi_chain[SYNC_STAGES-1];

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [WORD_SIZE-1:0] r_rx_shift, r_tx_shift, r_tx_latch;
  logic                 r_tx_full, r_reload, r_miso;
  logic                 r_rx_restart;
  logic [RX_TW-1:0]     r_rx_tmr;
  logic [TX_TW-1:0]     r_tx_tmr;

  logic                 w_at_end, w_sh_act, w_load, w_done;
  logic [WORD_SIZE-1:0] w_tx_word;

  assign w_at_end  = (r_bit_cnt == CNT_W'(WORD_SIZE));
  assign w_sh_act  = (r_state == ST_SHIFT) && !w_at_end && !w_cs_rise;
  // frame start: cs falling, or first sclk fall after DONE when cs stayed low
  assign w_load    = ((r_state == ST_IDLE) && w_cs_fall) ||
                     (w_sh_act && w_sclk_fall && r_reload);
  assign w_done    = (r_state == ST_DONE);
  assign w_tx_word = r_tx_full ? r_tx_latch : IDLE_MISO_WORD;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_at_end)       w_state_nxt = ST_DONE;
        else if (w_cs_rise) w_state_nxt = ST_IDLE;
      end
      ST_DONE:  w_state_nxt = w_cs_sync ? ST_IDLE : ST_SHIFT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
      r_reload   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_reload  <= 1'b0;
          r_miso    <= 1'b0;
          if (w_load) begin
            r_tx_shift <= w_tx_word;
            r_miso     <= w_tx_word[WORD_SIZE-1];
          end
        end
        ST_SHIFT: begin
          if (!w_at_end) begin
            if (w_cs_rise) begin
              // abort, or clean end after DONE when bit count is already 0
              r_bit_cnt <= '0;
              r_reload  <= 1'b0;
              r_miso    <= 1'b0;
            end else if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[WORD_SIZE-2:0], w_mosi};
              r_bit_cnt  <= r_bit_cnt + 1'b1;
            end else if (w_sclk_fall) begin
              if (w_load) begin
                r_tx_shift <= w_tx_word;
                r_miso     <= w_tx_word[WORD_SIZE-1];
                r_reload   <= 1'b0;
              end else begin
                r_tx_shift <= r_tx_shift << 1;
                r_miso     <= r_tx_shift[WORD_SIZE-2];
              end
            end
          end
        end
        ST_DONE: begin
          r_bit_cnt <= '0;
          r_reload  <= 1'b1;
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  // tx latch: a write in the same cycle as DONE must survive the clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_latch <= '0;
      r_tx_full  <= 1'b0;
    end else if (i_tx_valid) begin
      r_tx_latch <= i_tx_data;
      r_tx_full  <= 1'b1;
    end else if (w_done) begin
      r_tx_full  <= 1'b0;
    end
  end

  // rx pulse: a word landing mid-pulse forces a one-cycle low gap so the
  // controller's edge detector sees a fresh rising edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      r_rx_tmr     <= '0;
      r_rx_restart <= 1'b0;
    end else if (w_done) begin
      o_rx_data <= r_rx_shift;
      if (o_rx_valid) begin
        o_rx_valid   <= 1'b0;
        r_rx_restart <= 1'b1;
      end else begin
        o_rx_valid <= 1'b1;
        r_rx_tmr   <= RX_TW'(RX_PULSE_CYCLES - 1);
      end
    end else if (r_rx_restart) begin
      r_rx_restart <= 1'b0;
      o_rx_valid   <= 1'b1;
      r_rx_tmr     <= RX_TW'(RX_PULSE_CYCLES - 1);
    end else if (o_rx_valid) begin
      if (r_rx_tmr == '0) o_rx_valid <= 1'b0;
      else                r_rx_tmr   <= r_rx_tmr - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_ready <= 1'b0;
      r_tx_tmr   <= '0;
    end else if (w_done) begin
      o_tx_ready <= 1'b1;
      r_tx_tmr   <= TX_TW'(TX_PULSE_CYCLES - 1);
    end else if (o_tx_ready) begin
      if (r_tx_tmr == '0) o_tx_ready <= 1'b0;
      else                r_tx_tmr   <= r_tx_tmr - 1'b1;
    end
  end

  assign o_spi_miso = r_miso;

`ifdef SPI_BUS_BRIDGE_ERR_CNT_EN
  logic       r_ld_empty;
  logic [7:0] r_abort_cnt, r_undr_cnt;
  logic       w_abort, w_undr;

  // bit count 0 at cs rise is the normal end after DONE, not an abort
  assign w_abort = (r_state == ST_SHIFT) && !w_at_end && w_cs_rise && (r_bit_cnt != '0);
  // an underrun is counted once the loaded frame actually clocks its first bit
  assign w_undr  = w_sh_act && w_sclk_rise && (r_bit_cnt == '0) && r_ld_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_empty  <= 1'b0;
      r_abort_cnt <= '0;
      r_undr_cnt  <= '0;
    end else begin
      if (w_load)                          r_ld_empty  <= !r_tx_full;
      if (w_abort && r_abort_cnt != 8'hFF) r_abort_cnt <= r_abort_cnt + 1'b1;
      if (w_undr && r_undr_cnt != 8'hFF)   r_undr_cnt  <= r_undr_cnt + 1'b1;
    end
  end

  assign o_err_cnt = {r_undr_cnt, r_abort_cnt};
`endif

endmodule

// File: doc/spi_bus_bridge.md
Name: spi_bus_bridge

Overview:
- SPI slave front end that sits between the external microcontroller's SPI master and the matrix controller.
- Deserialises 16-bit MOSI frames into valid/data words, which drive spi_2_bus_if.
- Serialises response words from bus_2_spi_if back onto MISO.
- Produces the level-style valid and ready signals the controller expects: the controller detects their rising edges through 2-flop shift registers.

Parameters:
- WORD_SIZE, 16: SPI frame and bus word width.
- SYNC_STAGES, 2: synchroniser depth for sclk, cs_n and mosi.
- RX_PULSE_CYCLES, 4: clk cycles rx_valid is held high per received word. Must be >= 2.
- TX_PULSE_CYCLES, 4: clk cycles tx_ready is held high per request. Must be >= 2.
- IDLE_MISO_WORD, 16'h0000: word shifted out when no response word is latched.

Ports:
- clk  in  1  system clock; must be >= 8x spi_sclk.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock; mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  slave-out data, MSB first.
- rx_valid  out  1  drives spi_2_bus_if.valid.
- rx_data  out  WORD_SIZE  drives spi_2_bus_if.data; stable while rx_valid is high.
- tx_ready  out  1  drives bus_2_spi_if.ready; requests the next response word.
- tx_valid  in  1  bus_2_spi_if.valid.
- tx_data  in  WORD_SIZE  bus_2_spi_if.data.

Behaviour:
- Reset values:
  - rx_valid=0, rx_data=0, tx_ready=0, spi_miso=0.
  - Bit counter=0, state=IDLE, tx latch empty.
- Synchronisation and edge detection:
  - sclk, cs_n and mosi each pass through a SYNC_STAGES flop chain.
  - Edge detection compares the last two synced samples.
  - Latency from a pin edge to internal action: SYNC_STAGES+1 clk cycles.
- State machine:
  - IDLE -> SHIFT on synced cs_n falling. Action: load the tx shift register from the tx latch, or IDLE_MISO_WORD if the latch is empty; drive its MSB on miso.
  - SHIFT, on each sclk rising: shift in mosi (MSB first) and increment the bit counter.
  - SHIFT, on each sclk falling: shift the tx register and present the next bit on miso.
  - SHIFT -> DONE when the bit counter reaches WORD_SIZE.
  - DONE, one cycle:
    - Copy the rx shift register to rx_data and start the rx pulse.
    - Mark the tx latch empty and start the tx_ready pulse.
    - Return to SHIFT if cs_n is still low (back-to-back frames), otherwise to IDLE.
  - Back-to-back frames: bit counter resets to 0 and the tx shift register reloads from the latch at the first sclk falling after DONE.
- rx pulse:
  - rx_valid is high for exactly RX_PULSE_CYCLES clk cycles.
  - If a new word completes while the pulse is active: drop rx_valid for 1 cycle, update rx_data, then restart the full pulse, so the controller sees a fresh rising edge.
- tx pulse:
  - tx_ready is high for TX_PULSE_CYCLES cycles.
  - tx_data is latched on any clk cycle where tx_valid=1, and the latch is marked full. tx_valid is honoured at any time, not only during the pulse.
  - A later tx_valid overwrites an unconsumed latch (last write wins).
- Chip-select abort:
  - cs_n rising in SHIFT before WORD_SIZE bits: discard the partial word, with no rx_valid and no tx_ready.
  - The tx latch is preserved. Go to IDLE; miso=0.
- cs_n high: sclk edges are ignored; miso is held 0.
- rst_n asserted mid-frame: everything returns to reset values immediately; in-flight bits are lost.

Optional Feature:
- Macro: SPI_BUS_BRIDGE_ERR_CNT_EN.
- When defined, adds output err_cnt[15:0]:
  - [7:0] = aborted frames.
  - [15:8] = tx underruns, i.e. frames started with the latch empty.
  - Both fields are saturating at 8'hFF and cleared by rst_n.
- When undefined: no port and no counters; behaviour is otherwise identical.

Decomposition:
- Package spi_bus_bridge_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the WORD_SIZE default;
  - the IDLE_MISO_WORD default;
  - the bit-counter width localparam, $clog2(WORD_SIZE+1).
- One sub-module, spi_pin_sync: per-signal synchroniser with rise/fall pulse outputs. Instantiated for sclk and cs_n; mosi uses its sync output only.

Test Plan:
- Frame 16'h4000 (WRITE_VEC opcode), cs_n held low for 16 sclk -> rx_data=16'h4000 and rx_valid high for exactly 4 clk cycles.
- tx_valid with tx_data=16'hA5C3 before a frame; master sends 16'h6000 -> miso bits read 16'hA5C3, then a tx_ready pulse of 4 cycles after bit 16.
- No tx_valid before a frame -> miso reads 16'h0000; err_cnt[15:8]=1 with ERR_CNT_EN.
- cs_n raised after 9 bits of 16'hFFFF -> no rx_valid; next full frame 16'h3000 gives rx_data=16'h3000; err_cnt[7:0]=1.
- Back-to-back frames 16'h1234 and 16'h5678 with cs_n low throughout -> two distinct rx_valid rising edges carrying the correct data in order.
- rst_n pulsed low at bit 7 -> all outputs 0; next full frame 16'h00FF is received correctly.
